// File: rtl/btn_press_decoder_if.sv
// -----------------------------------------------------------------------------
// btn_press_decoder_if
// Bundle of the button input and the decoded press-event outputs.
//
// Signals:
//   i_btn          raw push-button level (driven by the board side)
//   o_pressed      debounced button level
//   o_short_press  one-cycle pulse, press released before the long threshold
//   o_long_press   one-cycle pulse, long threshold reached while held
//   o_repeat_pulse one-cycle auto-repeat pulse while long-held
//   o_press_count  8-bit wrapping count of accepted presses
//
// Modports:
//   master  drives i_btn, observes the decoded outputs
//   slave   the decoder itself
// -----------------------------------------------------------------------------
interface btn_press_decoder_if;
  logic       i_btn;
  logic       o_pressed;
  logic       o_short_press;
  logic       o_long_press;
  logic       o_repeat_pulse;
  logic [7:0] o_press_count;

  modport master (
    output i_btn,
    input  o_pressed,
    input  o_short_press,
    input  o_long_press,
    input  o_repeat_pulse,
    input  o_press_count
  );

  modport slave (
    input  i_btn,
    output o_pressed,
    output o_short_press,
    output o_long_press,
    output o_repeat_pulse,
    output o_press_count
  );
endinterface

// File: rtl/btn_press_decoder.sv
// -----------------------------------------------------------------------------
// btn_press_decoder
// Turns one raw, bouncing, asynchronous push-button into clean press events:
// 2-flop synchronizer, debounce of both edges, short/long press classification
// and an 8-bit wrapping press counter.
//
// Ports:
//   clk    system clock, everything on the rising edge
//   reest  synchronous active-low reset
//   bus    btn_press_decoder_if.slave (button in, decoded events out)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept an edge (>=1)
//   LONG_CYCLES      hold time after an accepted press that makes it long (>=1)
//   REPEAT_CYCLES    auto-repeat period while long-held
//
// Optional feature macro: BTN_REPEAT_EN
//   defined   -> repeat_pulse fires every REPEAT_CYCLES while held in LONG
//   undefined -> no repeat counter, repeat_pulse is tied low
// -----------------------------------------------------------------------------
module btn_press_decoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input logic                clk,
  input logic                reest,
  btn_press_decoder_if.slave bus
);

  localparam int MAXP = (DEBOUNCE_CYCLES > LONG_CYCLES)
                      ? ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES)
                      : ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES);
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] DEB_C  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    LONG,
    DB_REL
  } state_t;

  logic          r_sync1, r_sync2;
  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [CW-1:0] r_holdCnt, w_holdCnt;
  logic          r_fromLong, w_fromLong;
  logic          r_short, w_short;
  logic          r_long, w_long;
  logic [7:0]    r_count, w_count;
  logic [CW-1:0] w_cntInc;
  logic          w_accept, w_release;
`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] REP_C = CW'(REPEAT_CYCLES);
  logic [CW-1:0] r_repCnt, w_repCnt;
  logic          r_repeat, w_repeat;
`endif

  // Next-state logic. w_accept / w_release collect the "debounce finished"
  // events from several states so the DEBOUNCE_CYCLES==1 shortcut (no
  // intermediate counting state) shares the same entry/exit actions.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_holdCnt  = r_holdCnt;
    w_fromLong = r_fromLong;
    w_short    = 1'b0;
    w_long     = 1'b0;
    w_count    = r_count;
    w_cntInc   = r_cnt + ONE_C;
    w_accept   = 1'b0;
    w_release  = 1'b0;
`ifdef BTN_REPEAT_EN
    w_repCnt   = r_repCnt;
    w_repeat   = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (r_sync2) begin
          w_cnt = ONE_C;
          if (DEB_C == ONE_C) w_accept = 1'b1;
          else                w_state  = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!r_sync2) begin
          w_state = IDLE;
        end else begin
          w_cnt = w_cntInc;
          if (w_cntInc == DEB_C) w_accept = 1'b1;
        end
      end
      HELD: begin
        // Release wins over the long threshold in the same cycle.
        if (!r_sync2) begin
          w_state    = DB_REL;
          w_cnt      = ONE_C;
          w_fromLong = 1'b0;
          if (DEB_C == ONE_C) w_release = 1'b1;
        end else if (r_holdCnt != LONG_C) begin
          w_holdCnt = r_holdCnt + ONE_C;
          if (r_holdCnt + ONE_C == LONG_C) begin
            w_state = LONG;
            w_long  = 1'b1;
`ifdef BTN_REPEAT_EN
            w_repCnt = '0;
`endif
          end
        end
      end
      LONG: begin
        if (!r_sync2) begin
          w_state    = DB_REL;
          w_cnt      = ONE_C;
          w_fromLong = 1'b1;
          if (DEB_C == ONE_C) w_release = 1'b1;
        end else begin
`ifdef BTN_REPEAT_EN
          if (r_repCnt + ONE_C == REP_C) begin
            w_repCnt = '0;
            w_repeat = 1'b1;
          end else begin
            w_repCnt = r_repCnt + ONE_C;
          end
`endif
        end
      end
      DB_REL: begin
        // A bounce back high resumes the press; hold/repeat counters
        // were left untouched so they continue where they stopped.
        if (r_sync2) begin
          w_state = r_fromLong ? LONG : HELD;
        end else begin
          w_cnt = w_cntInc;
          if (w_cntInc == DEB_C) w_release = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_accept) begin
      w_state   = HELD;
      w_holdCnt = '0;
      w_count   = r_count + 8'd1;
    end
    if (w_release) begin
      w_state = IDLE;
      w_short = ~w_fromLong;
`ifdef BTN_REPEAT_EN
      w_repCnt = '0;
`endif
    end
  end

  // State and output registers, plus the synchronizer feeding the FSM.
  always_ff @(posedge clk) begin
    if (!reest) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_holdCnt  <= '0;
      r_fromLong <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_count    <= 8'd0;
`ifdef BTN_REPEAT_EN
      r_repCnt   <= '0;
      r_repeat   <= 1'b0;
`endif
    end else begin
      r_sync1    <= bus.i_btn;
      r_sync2    <= r_sync1;
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_holdCnt  <= w_holdCnt;
      r_fromLong <= w_fromLong;
      r_short    <= w_short;
      r_long     <= w_long;
      r_count    <= w_count;
`ifdef BTN_REPEAT_EN
      r_repCnt   <= w_repCnt;
      r_repeat   <= w_repeat;
`endif
    end
  end

  // pressed is a decode of the state register, so it is registered too.
  assign bus.o_pressed     = (r_state == HELD) || (r_state == LONG) || (r_state == DB_REL);
  assign bus.o_short_press = r_short;
  assign bus.o_long_press  = r_long;
  assign bus.o_press_count = r_count;
`ifdef BTN_REPEAT_EN
  assign bus.o_repeat_pulse = r_repeat;
`else
  assign bus.o_repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_press_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_press_decoder
// Directed bench for btn_press_decoder with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=20, REPEAT_CYCLES=5 and a 10 ns clock. Honours BTN_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_btn_press_decoder;

`ifdef BTN_REPEAT_EN
  localparam int EXP_REP = 3;
`else
  localparam int EXP_REP = 0;
`endif

  logic clk;
  logic reest;
  btn_press_decoder_if ifc ();

  btn_press_decoder #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk  (clk),
    .reest(reest),
    .bus  (ifc)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cycle = 0;
  int nShort, nLong, nRep, nRise, nFall;
  int shortCycle, longCycle, repFirst, riseCycle, fallCycle;
  bit prevPressed = 1'b0;
  int c0, c1;

  task automatic clearStats();
    nShort = 0; nLong = 0; nRep = 0; nRise = 0; nFall = 0;
    shortCycle = -1; longCycle = -1; repFirst = -1; riseCycle = -1; fallCycle = -1;
  endtask

  // Advance one clock and sample 1 ns after the rising edge, logging events.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (ifc.o_short_press === 1'b1) begin nShort++; shortCycle = cycle; end
    if (ifc.o_long_press  === 1'b1) begin nLong++;  longCycle  = cycle; end
    if (ifc.o_repeat_pulse === 1'b1) begin
      nRep++;
      if (repFirst < 0) repFirst = cycle;
    end
    if (ifc.o_pressed === 1'b1 && !prevPressed) begin nRise++; riseCycle = cycle; end
    if (ifc.o_pressed !== 1'b1 && prevPressed)  begin nFall++; fallCycle = cycle; end
    prevPressed = (ifc.o_pressed === 1'b1);
  endtask

  task automatic applyStimulus(input logic b, input int n);
    ifc.i_btn = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    clearStats();
    ifc.i_btn = 1'b1;
    reest     = 1'b0;
    #1;

    // Reset held with button high: everything quiet.
    for (int i = 0; i < 3; i++) tick();
    checkOutput("rst_pressed", 32'(ifc.o_pressed), 0);
    checkOutput("rst_short",   32'(ifc.o_short_press), 0);
    checkOutput("rst_long",    32'(ifc.o_long_press), 0);
    checkOutput("rst_repeat",  32'(ifc.o_repeat_pulse), 0);
    checkOutput("rst_count",   32'(ifc.o_press_count), 0);

    // Reset exit with button still high: pressed after 6 clocks.
    clearStats();
    c0 = cycle;
    reest = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rst_exit_not_yet", 32'(ifc.o_pressed), 0);
    tick();
    checkOutput("rst_exit_pressed", 32'(ifc.o_pressed), 1);
    checkOutput("rst_exit_rise",    32'(riseCycle), 32'(c0 + 6));
    checkOutput("rst_exit_count",   32'(ifc.o_press_count), 1);
    applyStimulus(1'b0, 10);
    checkOutput("rst_exit_short", 32'(nShort), 1);

    // Glitch of 3 samples: rejected.
    clearStats();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 10);
    checkOutput("glitch_rise",  32'(nRise), 0);
    checkOutput("glitch_short", 32'(nShort), 0);
    checkOutput("glitch_long",  32'(nLong), 0);
    checkOutput("glitch_count", 32'(ifc.o_press_count), 1);

    // Short press: 10 high, then low.
    clearStats();
    c0 = cycle;
    applyStimulus(1'b1, 10);
    checkOutput("short_rise", 32'(riseCycle), 32'(c0 + 6));
    c1 = cycle;
    applyStimulus(1'b0, 10);
    checkOutput("short_fall",   32'(fallCycle), 32'(c1 + 6));
    checkOutput("short_pulseT", 32'(shortCycle), 32'(c1 + 6));
    checkOutput("short_num",    32'(nShort), 1);
    checkOutput("short_nolong", 32'(nLong), 0);
    checkOutput("short_count",  32'(ifc.o_press_count), 2);

    // Long press: 40 high, then low.
    clearStats();
    c0 = cycle;
    applyStimulus(1'b1, 40);
    checkOutput("long_rise",  32'(riseCycle), 32'(c0 + 6));
    checkOutput("long_pulseT", 32'(longCycle), 32'(c0 + 26));
    checkOutput("long_num",   32'(nLong), 1);
    c1 = cycle;
    applyStimulus(1'b0, 10);
    checkOutput("long_fall",    32'(fallCycle), 32'(c1 + 6));
    checkOutput("long_noshort", 32'(nShort), 0);
    checkOutput("long_repeats", 32'(nRep), 32'(EXP_REP));
`ifdef BTN_REPEAT_EN
    checkOutput("long_rep_first", 32'(repFirst), 32'(c0 + 31));
`endif
    checkOutput("long_count", 32'(ifc.o_press_count), 3);

    // Release bounce: low 2, high 2, low 10 -> a single short press.
    clearStats();
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 10);
    checkOutput("bounce_short", 32'(nShort), 1);
    checkOutput("bounce_rise",  32'(nRise), 1);
    checkOutput("bounce_fall",  32'(nFall), 1);
    checkOutput("bounce_count", 32'(ifc.o_press_count), 4);

    // Bounce while held, then long: hold counter resumes, so the 3 frozen
    // clocks push long_press to 23 clocks after pressed rose.
    clearStats();
    c0 = cycle;
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 10);
    checkOutput("resume_long_T", 32'(longCycle), 32'(c0 + 29));
    checkOutput("resume_nlong",  32'(nLong), 1);
    checkOutput("resume_nshort", 32'(nShort), 0);
    checkOutput("resume_count",  32'(ifc.o_press_count), 5);

    // Wrap: 250 more presses to 255, one more to 0.
    clearStats();
    for (int p = 0; p < 250; p++) begin
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 8);
    end
    checkOutput("wrap_255", 32'(ifc.o_press_count), 255);
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 8);
    checkOutput("wrap_0",      32'(ifc.o_press_count), 0);
    checkOutput("wrap_shorts", 32'(nShort), 251);
    checkOutput("wrap_nolong", 32'(nLong), 0);

    // Reset in the middle of a held press.
    clearStats();
    applyStimulus(1'b1, 10);
    checkOutput("midrst_held", 32'(ifc.o_pressed), 1);
    reest = 1'b0;
    tick();
    checkOutput("midrst_pressed", 32'(ifc.o_pressed), 0);
    checkOutput("midrst_count",   32'(ifc.o_press_count), 0);
    reest = 1'b1;
    applyStimulus(1'b0, 10);
    checkOutput("midrst_noshort", 32'(nShort), 0);
    checkOutput("midrst_nolong",  32'(nLong), 0);
    checkOutput("midrst_idle",    32'(ifc.o_pressed), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
